// File: rtl/mux_pkg.sv
// mux_pkg: shared width constant and data type for the select/skid datapath.
package mux_pkg;
    localparam int DATA_W = 64;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: output register plus one skid entry; in_ready is registered (skid empty).
module skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    assign in_ready = !skid_valid;

    // A full skid implies a full main register, so only a drain can move it forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid || out_ready) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mux_2to1.sv
// mux_2to1: 2:1 word select with a zero-latency output and an optional
// registered valid/ready output backed by a skid buffer.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH      = DATA_W,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             sig,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_comb
);
    // if/else rather than ?: so an unknown select falls through to in_0 in simulation
    always_comb begin
        if (sig) out_comb = in_1;
        else out_comb = in_0;
    end

    generate
        if (REGISTERED) begin : g_reg
            skid_buffer #(.WIDTH(WIDTH)) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (out_comb),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (out)
            );
        end else begin : g_comb
            assign out       = out_comb;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end
    endgenerate
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: registered and pass-through builds driven side by side and
// checked against a 2-deep FIFO reference model.
module tb_mux_2to1;
    import mux_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    data_t in_0, in_1;
    logic  sig, in_valid, out_ready;
    data_t out_r, out_comb_r, out_c, out_comb_c;
    logic  in_ready_r, out_valid_r, in_ready_c, out_valid_c;
    data_t q[$];
    int    total = 0;
    int    bad = 0;
    logic  acc, drain;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(DATA_W), .REGISTERED(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .in_0(in_0), .in_1(in_1), .sig(sig),
        .in_valid(in_valid), .in_ready(in_ready_r), .out(out_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_comb(out_comb_r)
    );

    mux_2to1 #(.WIDTH(DATA_W), .REGISTERED(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_0(in_0), .in_1(in_1), .sig(sig),
        .in_valid(in_valid), .in_ready(in_ready_c), .out(out_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_comb(out_comb_c)
    );

    function automatic data_t pick(data_t a, data_t b, logic s);
        return (s === 1'b1) ? b : a;
    endfunction

    task automatic chk(string tag, data_t got, data_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(string tag, logic got, logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("out_comb_reg", out_comb_r, pick(in_0, in_1, sig));
        chk("out_comb_pass", out_comb_c, pick(in_0, in_1, sig));
        chk1("out_valid", out_valid_r, q.size() != 0);
        if (q.size() != 0) chk("out_data", out_r, q[0]);
        chk1("in_ready", in_ready_r, q.size() < 2);
        chk("pass_out", out_c, pick(in_0, in_1, sig));
        chk1("pass_valid", out_valid_c, in_valid);
        chk1("pass_ready", in_ready_c, out_ready);
    endtask

    task automatic cycle();
        #1 check_all();
        acc   = in_valid && (q.size() < 2) && rst_n;
        drain = (q.size() != 0) && out_ready && rst_n;
        @(posedge clk);
        if (drain) void'(q.pop_front());
        if (acc) q.push_back(pick(in_0, in_1, sig));
        @(negedge clk);
    endtask

    task automatic drive(data_t a, data_t b, logic s, logic v, logic r);
        in_0 = a; in_1 = b; sig = s; in_valid = v; out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out", out_r, '0);
        chk1("reset_valid", out_valid_r, 1'b0);
        chk1("reset_pass_valid", out_valid_c, in_valid);
        chk1("reset_pass_ready", in_ready_c, out_ready);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // combinational select, including an unknown select
        drive('0, '1, 1'b0, 1'b0, 1'b1);
        #1 chk("sel0", out_comb_r, '0);
        sig = 1'b1;
        #1 chk("sel1", out_comb_r, '1);
        sig = 1'bx;
        #1 chk("selx", out_comb_r, '0);
        @(negedge clk);

        // one-cycle latency
        drive(64'h1234, 64'hABCD, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(64'h1234, 64'hABCD, 1'b1, 1'b0, 1'b1);
        #1 chk("latency_out", out_r, 64'hABCD);
        chk1("latency_valid", out_valid_r, 1'b1);
        cycle();

        // back-to-back streaming with alternating select
        for (int i = 0; i < 8; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, i[0], 1'b1, 1'b1);
            cycle();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b1);
        cycle();

        // backpressure: three offered, two held, then drain
        for (int i = 0; i < 3; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, i[0], 1'b1, 1'b0);
            cycle();
        end
        chk1("bp_ready_low", in_ready_r, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive('0, '0, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        chk1("bp_ready_back", in_ready_r, 1'b1);

        // async reset mid-stream with held words
        drive(64'h55, 64'hAA, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out", out_r, '0);
        chk1("midreset_valid", out_valid_r, 1'b0);
        chk1("midreset_pass_valid", out_valid_c, in_valid);
        q.delete();
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 chk1("post_reset_ready", in_ready_r, 1'b1);
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterised 2:1 word multiplexer for datapath operand/result selection, e.g. PC-next, ALU operand-B and writeback select.
- Selects `in_1` when `sig`=1, otherwise `in_0`.
- Provides two output forms:
  - a combinational path, `out_comb`;
  - a one-stage registered path with a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages without breaking timing.
- Single clock domain.

Parameters:
- WIDTH, 64, data width of `in_0`, `in_1`, `out`, `out_comb`.
- REGISTERED, 1, 1 = `out` driven from the output register; 0 = `out` equals `out_comb` and handshake is pass-through.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_0  input  WIDTH  data selected when `sig`=0.
- in_1  input  WIDTH  data selected when `sig`=1.
- sig  input  1  select.
- in_valid  input  1  upstream word (`in_0`/`in_1`/`sig`) valid.
- in_ready  output  1  block can accept a word this cycle.
- out  output  WIDTH  selected data (registered or combinational per REGISTERED).
- out_valid  output  1  `out` holds a valid word.
- out_ready  input  1  downstream accepts `out` this cycle.
- out_comb  output  WIDTH  always `sig ? in_1 : in_0`, zero latency, independent of handshake.

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- Select resolution:
  - `sig`=1 selects `in_1`.
  - `sig`=0 selects `in_0`.
  - `sig` X/Z (simulation) resolves to `in_0`, so `out` never becomes X from an unknown select.
- out_comb: purely combinational in both modes; no dependence on `clk` or `rst_n`.
- Reset (`rst_n`=0, asynchronous):
  - `out` = 0, `out_valid` = 0, skid entry empty, `in_ready` = 1 as soon as `rst_n` deasserts.
  - Reset asserted mid-transfer discards all held words; no partial word survives.
- REGISTERED=1:
  - Accept when `in_valid & in_ready`; the selected word is captured at the rising edge.
  - Latency: 1 cycle from accept to `out_valid`=1.
  - Transfer out when `out_valid & out_ready`.
  - Main register plus 1 skid entry:
    - `in_ready` = skid empty (registered signal, no combinational path from `out_ready`).
    - Accept while main is full and not draining → word goes to the skid entry; `in_ready` drops next cycle.
    - Main drains while skid is full → skid moves to main; `in_ready` rises next cycle.
  - Simultaneous accept and drain with main full and skid empty: new word loads main directly, skid stays empty.
  - `out` and `out_valid` hold stable while `out_valid & !out_ready` (no data change under backpressure).
  - Throughput: 1 word/cycle when `out_ready` is held high.
  - Order preserved; no duplication, no loss.
- REGISTERED=0:
  - `out` = `out_comb`, `out_valid` = `in_valid`, `in_ready` = `out_ready`.
  - No storage; reset affects nothing.
- Arithmetic: none. Width is fixed at WIDTH; no extension or truncation.

Decomposition:
- Shared package `mux_pkg`:
  - constant DATA_W = 64;
  - typedef `data_t` (logic [DATA_W-1:0]).
  - `mux_2to1` uses DATA_W as the WIDTH default.
- One sub-module: `skid_buffer` (WIDTH; ports `clk`, `rst_n`, `in_valid`/`in_ready`/`in_data`, `out_valid`/`out_ready`/`out_data`).
  - `mux_2to1` instantiates it under REGISTERED=1.
  - It carries the selection result from the combinational select logic.

Test Plan:
- Combinational select: `in_0`=64'h0, `in_1`=64'hFFFF_FFFF_FFFF_FFFF, `sig`=0 → `out_comb`=0; `sig`=1 → `out_comb`=64'hFFFF_FFFF_FFFF_FFFF with zero delay; `sig`=X → `out_comb`=0.
- Reset: drive `rst_n`=0 mid-stream with `out_valid`=1 → `out`=0 and `out_valid`=0 immediately, without waiting for a clock edge; after release `in_ready`=1.
- Registered latency: `in_0`=64'h1234, `in_1`=64'hABCD, `sig`=1, `in_valid`=1, `out_ready`=1 → the next cycle `out`=64'hABCD with `out_valid`=1.
- Streaming: 8 back-to-back words with `out_ready`=1 and `sig` alternating → 8 outputs on consecutive cycles, in order, each matching its select.
- Backpressure: `out_ready`=0 while sending 3 words → 2 accepted, `in_ready` low on cycle 3, `out` stable; raise `out_ready` → words drain in order and `in_ready` returns high.
- REGISTERED=0 build: `out` tracks `out_comb`, `out_valid`=`in_valid`, `in_ready`=`out_ready` in every cycle, including during reset.
